// File: rtl/fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : fifo_write_arbiter
// Brief   : Round-robin write arbiter for two requesters feeding one FIFO.
//           Also tracks occupancy and flags almost-full and underflow.
// Revision: 1.0 - initial release
// ============================================================================
module fifo_write_arbiter #(
    parameter int regWidth        = 8,
    parameter int addrSize        = 3,
    parameter int almostFullLevel = 6
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                req0,
    input  logic                req1,
    input  logic [regWidth-1:0] data0,
    input  logic [regWidth-1:0] data1,
    output logic                ack0,
    output logic                ack1,
    input  logic                rEnable_in,
    output logic                wEnable,
    output logic [regWidth-1:0] wData,
    output logic                rEnable,
    input  logic                fifoEmpty,
    input  logic                fifoFull,
    output logic [addrSize:0]   count,
    output logic                almostFull,
    output logic                underflowErr,
    input  logic                errClear
);

    localparam int              DEPTH    = 2 ** addrSize;
    localparam logic [addrSize:0] C_DEPTH  = (addrSize + 1)'(DEPTH);
    localparam logic [addrSize:0] C_ALMOST = (addrSize + 1)'(almostFullLevel);

    logic                w_enable_q,    w_enable_d;
    logic [regWidth-1:0] w_data_q,      w_data_d;
    logic                ack0_q,        ack0_d;
    logic                ack1_q,        ack1_d;
    logic [addrSize:0]   count_q,       count_d;
    logic                almost_full_q, almost_full_d;
    logic                underflow_q,   underflow_d;
    logic                last_grant_q,  last_grant_d;

    logic w_room;
    logic w_elig0;
    logic w_elig1;
    logic w_grant0;
    logic w_grant1;
    logic w_grant;
    logic w_read;
    logic w_dec;
    logic w_underflow;

    always_comb begin
        w_room      = (count_q < C_DEPTH) && !fifoFull;
        // A requester whose ack is high this cycle has its word already
        // written; blocking it stops a double write before req drops.
        w_elig0     = req0 && !ack0_q && w_room;
        w_elig1     = req1 && !ack1_q && w_room;
        w_grant0    = w_elig0 && (!w_elig1 || last_grant_q);
        w_grant1    = w_elig1 && !w_grant0;
        w_grant     = w_grant0 || w_grant1;
        w_read      = rEnable_in && !fifoEmpty;
        w_dec       = w_read && (count_q != '0);
        w_underflow = rEnable_in && fifoEmpty;
    end

    always_comb begin
        w_enable_d    = w_grant;
        w_data_d      = w_data_q;
        ack0_d        = w_grant0;
        ack1_d        = w_grant1;
        last_grant_d  = last_grant_q;
        count_d       = count_q;
        underflow_d   = underflow_q;
        almost_full_d = almost_full_q;

        if (w_grant0) begin
            w_data_d     = data0;
            last_grant_d = 1'b0;
        end else if (w_grant1) begin
            w_data_d     = data1;
            last_grant_d = 1'b1;
        end

        case ({w_grant, w_dec})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A fresh underflow outranks a clear in the same cycle.
        if (w_underflow) begin
            underflow_d = 1'b1;
        end else if (errClear) begin
            underflow_d = 1'b0;
        end

        almost_full_d = (count_d >= C_ALMOST);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            w_enable_q    <= 1'b0;
            w_data_q      <= '0;
            ack0_q        <= 1'b0;
            ack1_q        <= 1'b0;
            count_q       <= '0;
            almost_full_q <= 1'b0;
            underflow_q   <= 1'b0;
            last_grant_q  <= 1'b1;
        end else begin
            w_enable_q    <= w_enable_d;
            w_data_q      <= w_data_d;
            ack0_q        <= ack0_d;
            ack1_q        <= ack1_d;
            count_q       <= count_d;
            almost_full_q <= almost_full_d;
            underflow_q   <= underflow_d;
            last_grant_q  <= last_grant_d;
        end
    end

    assign wEnable      = w_enable_q;
    assign wData        = w_data_q;
    assign ack0         = ack0_q;
    assign ack1         = ack1_q;
    assign count        = count_q;
    assign almostFull   = almost_full_q;
    assign underflowErr = underflow_q;
    assign rEnable      = w_read;

endmodule
`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_fifo_write_arbiter
// Brief   : Directed and randomized self-checking bench for fifo_write_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fifo_write_arbiter;

    localparam int W     = 8;
    localparam int A     = 3;
    localparam int AF    = 6;
    localparam int DEPTH = 8;

    logic         clk = 1'b0;
    logic         n_rst;
    logic         req0, req1, rEnable_in, fifoEmpty, fifoFull, errClear;
    logic [W-1:0] data0, data1;
    logic         ack0, ack1, wEnable, rEnable, almostFull, underflowErr;
    logic [W-1:0] wData;
    logic [A:0]   count;

    int checks   = 0;
    int failures = 0;

    // Behavioural reference state
    int           m_count;
    int           m_last;
    bit           m_ack0, m_ack1, m_wen, m_af, m_uf;
    logic [W-1:0] m_wdata;

    always #5 clk = ~clk;

    fifo_write_arbiter #(
        .regWidth       (W),
        .addrSize       (A),
        .almostFullLevel(AF)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .req0        (req0),
        .req1        (req1),
        .data0       (data0),
        .data1       (data1),
        .ack0        (ack0),
        .ack1        (ack1),
        .rEnable_in  (rEnable_in),
        .wEnable     (wEnable),
        .wData       (wData),
        .rEnable     (rEnable),
        .fifoEmpty   (fifoEmpty),
        .fifoFull    (fifoFull),
        .count       (count),
        .almostFull  (almostFull),
        .underflowErr(underflowErr),
        .errClear    (errClear)
    );

    task automatic model_reset();
        m_count = 0; m_last = 1; m_ack0 = 0; m_ack1 = 0;
        m_wen = 0; m_af = 0; m_uf = 0; m_wdata = '0;
    endtask

    // Predicts the registered outputs after the coming edge from current inputs.
    task automatic model_edge();
        bit e0, e1, rd;
        int g;
        e0 = req0 && !m_ack0 && (m_count < DEPTH) && !fifoFull;
        e1 = req1 && !m_ack1 && (m_count < DEPTH) && !fifoFull;
        g  = -1;
        if (e0 && e1) g = 1 - m_last;
        else if (e0)  g = 0;
        else if (e1)  g = 1;
        rd = rEnable_in && !fifoEmpty;
        m_wen  = (g >= 0);
        m_ack0 = (g == 0);
        m_ack1 = (g == 1);
        if (g == 0) m_wdata = data0;
        if (g == 1) m_wdata = data1;
        if (g >= 0) m_last = g;
        m_count = m_count + ((g >= 0) ? 1 : 0) - ((rd && m_count > 0) ? 1 : 0);
        m_uf = (rEnable_in && fifoEmpty) || (m_uf && !errClear);
        m_af = (m_count >= AF);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req0 = 0; req1 = 0; data0 = '0; data1 = '0;
        rEnable_in = 0; fifoEmpty = 0; fifoFull = 0; errClear = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        @(negedge clk);
        n_rst = 0;
        model_reset();
        @(negedge clk);
        n_rst = 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        n_rst = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({wEnable, ack0, ack1, almostFull, underflowErr} !== 5'b0 || wData !== '0 || count !== '0) begin
            failures++;
            $display("FAIL reset_state: wEn=%b ack0=%b ack1=%b af=%b uf=%b wData=%h count=%0d, required all zero",
                     wEnable, ack0, ack1, almostFull, underflowErr, wData, count);
        end
        @(negedge clk);
        n_rst = 1;
    endtask

    task automatic test_single_write();
        do_reset();
        req0 = 1; data0 = 8'hA5;
        tick();
        checks++;
        if (wEnable !== 1'b1 || wData !== 8'hA5 || ack0 !== 1'b1 || ack1 !== 1'b0 || count !== 4'd1) begin
            failures++;
            $display("FAIL single_write: wEn=%b wData=%h ack0=%b ack1=%b count=%0d, required 1 a5 1 0 1",
                     wEnable, wData, ack0, ack1, count);
        end
        req0 = 0;
        tick();
        checks++;
        if (wEnable !== 1'b0 || ack0 !== 1'b0 || count !== 4'd1) begin
            failures++;
            $display("FAIL single_write_idle: wEn=%b ack0=%b count=%0d, required 0 0 1", wEnable, ack0, count);
        end
    endtask

    task automatic test_fill_alternate();
        do_reset();
        req0 = 1; req1 = 1; data0 = 8'h11; data1 = 8'h22;
        for (int k = 1; k <= 10; k++) begin
            bit exp_g0, exp_g1;
            int exp_cnt;
            tick();
            exp_g0  = (k <= DEPTH) && (k % 2 == 1);
            exp_g1  = (k <= DEPTH) && (k % 2 == 0);
            exp_cnt = (k <= DEPTH) ? k : DEPTH;
            checks++;
            if (ack0 !== exp_g0 || ack1 !== exp_g1 || wEnable !== (exp_g0 | exp_g1) ||
                int'(count) != exp_cnt || almostFull !== (exp_cnt >= AF)) begin
                failures++;
                $display("FAIL fill_alternate cycle %0d: ack0=%b ack1=%b wEn=%b count=%0d af=%b, required %b %b %b %0d %b",
                         k, ack0, ack1, wEnable, count, almostFull, exp_g0, exp_g1,
                         exp_g0 | exp_g1, exp_cnt, exp_cnt >= AF);
            end
            if (exp_g0 || exp_g1) begin
                checks++;
                if (wData !== (exp_g0 ? 8'h11 : 8'h22)) begin
                    failures++;
                    $display("FAIL fill_alternate_data cycle %0d: wData=%h, required %h",
                             k, wData, exp_g0 ? 8'h11 : 8'h22);
                end
            end
        end
    endtask

    // Continues from a full FIFO left by test_fill_alternate.
    task automatic test_full_read();
        req0 = 0; req1 = 1; data1 = 8'h5C; rEnable_in = 1; fifoEmpty = 0;
        tick();
        checks++;
        if (wEnable !== 1'b0 || ack1 !== 1'b0 || count !== 4'd7) begin
            failures++;
            $display("FAIL full_read_block: wEn=%b ack1=%b count=%0d, required 0 0 7", wEnable, ack1, count);
        end
        rEnable_in = 0;
        tick();
        checks++;
        if (wEnable !== 1'b1 || ack1 !== 1'b1 || wData !== 8'h5C || count !== 4'd8) begin
            failures++;
            $display("FAIL full_read_grant: wEn=%b ack1=%b wData=%h count=%0d, required 1 1 5c 8",
                     wEnable, ack1, wData, count);
        end
    endtask

    task automatic test_grant_and_read();
        do_reset();
        req0 = 1; req1 = 1; data0 = 8'h31; data1 = 8'h32;
        repeat (3) tick();
        req0 = 0; rEnable_in = 1; fifoEmpty = 0;
        tick();
        checks++;
        if (wEnable !== 1'b1 || ack1 !== 1'b1 || count !== 4'd3 || wData !== 8'h32) begin
            failures++;
            $display("FAIL grant_and_read: wEn=%b ack1=%b count=%0d wData=%h, required 1 1 3 32",
                     wEnable, ack1, count, wData);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        fifoEmpty = 1; rEnable_in = 1;
        #1;
        checks++;
        if (rEnable !== 1'b0) begin
            failures++;
            $display("FAIL underflow_rEnable: rEnable=%b, required 0", rEnable);
        end
        tick();
        checks++;
        if (underflowErr !== 1'b1 || count !== 4'd0) begin
            failures++;
            $display("FAIL underflow_set: uf=%b count=%0d, required 1 0", underflowErr, count);
        end
        errClear = 1;
        tick();
        checks++;
        if (underflowErr !== 1'b1) begin
            failures++;
            $display("FAIL underflow_beats_clear: uf=%b, required 1", underflowErr);
        end
        rEnable_in = 0;
        tick();
        checks++;
        if (underflowErr !== 1'b0) begin
            failures++;
            $display("FAIL underflow_clear: uf=%b, required 0", underflowErr);
        end
        errClear = 0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req0 = 1; req1 = 1; data0 = 8'h41; data1 = 8'h42;
        repeat (5) tick();
        checks++;
        if (count !== 4'd5) begin
            failures++;
            $display("FAIL reset_mid_setup: count=%0d, required 5", count);
        end
        req0 = 0;
        #2;
        n_rst = 0;
        #1;
        checks++;
        if ({wEnable, ack0, ack1, almostFull, underflowErr} !== 5'b0 || wData !== '0 || count !== '0) begin
            failures++;
            $display("FAIL reset_mid_async: wEn=%b ack0=%b ack1=%b af=%b uf=%b wData=%h count=%0d, required all zero",
                     wEnable, ack0, ack1, almostFull, underflowErr, wData, count);
        end
        model_reset();
        @(negedge clk);
        n_rst = 1;
        req0 = 1; req1 = 1;
        tick();
        checks++;
        if (ack0 !== 1'b1 || ack1 !== 1'b0 || wData !== 8'h41 || count !== 4'd1) begin
            failures++;
            $display("FAIL reset_mid_tie: ack0=%b ack1=%b wData=%h count=%0d, required 1 0 41 1",
                     ack0, ack1, wData, count);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if (req0 && m_ack0) begin req0 = $urandom_range(0, 1); data0 = W'($urandom); end
            else if (!req0)     begin req0 = ($urandom_range(0, 2) == 0); data0 = W'($urandom); end
            if (req1 && m_ack1) begin req1 = $urandom_range(0, 1); data1 = W'($urandom); end
            else if (!req1)     begin req1 = ($urandom_range(0, 2) == 0); data1 = W'($urandom); end
            rEnable_in = ($urandom_range(0, 9) < 4);
            fifoEmpty  = (m_count == 0) || ($urandom_range(0, 15) == 0);
            fifoFull   = ($urandom_range(0, 15) == 0);
            errClear   = ($urandom_range(0, 9) == 0);
            #1;
            checks++;
            if (rEnable !== (rEnable_in && !fifoEmpty)) begin
                failures++;
                $display("FAIL random_rEnable cycle %0d: rEnable=%b, required %b",
                         c, rEnable, rEnable_in && !fifoEmpty);
            end
            tick();
            checks++;
            if (wEnable !== m_wen || ack0 !== m_ack0 || ack1 !== m_ack1 || int'(count) != m_count ||
                almostFull !== m_af || underflowErr !== m_uf || (m_wen && wData !== m_wdata)) begin
                failures++;
                $display("FAIL random_outputs cycle %0d: wEn=%b ack0=%b ack1=%b count=%0d af=%b uf=%b wData=%h, required %b %b %b %0d %b %b %h",
                         c, wEnable, ack0, ack1, count, almostFull, underflowErr, wData,
                         m_wen, m_ack0, m_ack1, m_count, m_af, m_uf, m_wdata);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_fill_alternate();
        test_full_read();
        test_grant_and_read();
        test_underflow();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_write_arbiter.md
FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 The block SHALL have parameter regWidth, default 8, meaning the FIFO data width in bits.
REQ-002 The block SHALL have parameter addrSize, default 3, meaning the FIFO pointer width; depth DEPTH = 2**addrSize.
REQ-003 The block SHALL have parameter almostFullLevel, default 6, meaning the occupancy at or above which almostFull asserts (range 1..DEPTH).
REQ-004 The block SHALL use one clock and an asynchronous active-low reset: clk  input  1  rising-edge clock.
REQ-005 The block SHALL have port n_rst  input  1  asynchronous active-low reset.
REQ-006 The block SHALL have ports req0, req1  input  1 each  write request from requester 0 and requester 1; each is held until its ack.
REQ-007 The block SHALL have ports data0, data1  input  regWidth each  write data; each is held stable while its req is high.
REQ-008 The block SHALL have ports ack0, ack1  output  1 each  one-cycle registered pulse meaning the word was accepted.
REQ-009 The block SHALL have port rEnable_in  input  1  consumer read request.
REQ-010 The block SHALL have port wEnable  output  1  registered FIFO write strobe.
REQ-011 The block SHALL have port wData  output  regWidth  registered FIFO write data.
REQ-012 The block SHALL have port rEnable  output  1  FIFO read strobe, equal to rEnable_in & ~fifoEmpty (combinational).
REQ-013 The block SHALL have ports fifoEmpty, fifoFull  input  1 each  FIFO status flags.
REQ-014 The block SHALL have port count  output  addrSize+1  occupancy, 0..DEPTH.
REQ-015 The block SHALL have port almostFull  output  1  registered flag, high when count >= almostFullLevel.
REQ-016 The block SHALL have port underflowErr  output  1  sticky flag: read attempted while empty.
REQ-017 The block SHALL have port errClear  input  1  synchronous clear of underflowErr.

Function
REQ-018 Eligibility: reqN SHALL be eligible when reqN=1, ackN=0 this cycle, count < DEPTH and fifoFull=0.
REQ-019 At each rising edge, at most one eligible requester SHALL be granted: wEnable<=1, wData<=dataN, ackN<=1; otherwise wEnable, ack0 and ack1 <= 0.
REQ-020 Priority SHALL be round-robin: when both are eligible, the requester not granted most recently wins; lastGrant updates only on a grant.
REQ-021 Latency: a request eligible at edge t SHALL see ack and wEnable high in cycle t..t+1, with wData valid in the same cycle.
REQ-022 The same requester SHALL NOT be granted on two consecutive cycles, which prevents a double write before req drops.
REQ-023 count SHALL update each edge: +1 on grant only, -1 on rEnable only, unchanged when both occur or neither occurs.
REQ-024 count SHALL never exceed DEPTH and never go below 0; with a read and a grant in the same cycle at count=DEPTH-1, the grant is allowed and count stays DEPTH-1.
REQ-025 At count=DEPTH, no grant SHALL issue, including when rEnable is high that cycle; the grant issues the following cycle.
REQ-026 rEnable_in=1 with fifoEmpty=1 SHALL set underflowErr at the next edge, leave count unchanged and keep rEnable=0.
REQ-027 errClear=1 SHALL clear underflowErr at the next edge; a simultaneous new underflow SHALL win and leave it set.
REQ-028 almostFull SHALL reflect the post-update count (registered alongside count).

Reset
REQ-029 When n_rst=0, asynchronously: wEnable=0, wData=0, ack0=0, ack1=0, count=0, almostFull=0, underflowErr=0, and lastGrant=1 so that req0 wins the first tie.
REQ-030 A reset mid-operation SHALL abandon any pending request without ack; requesters re-present after reset release.

Verification
REQ-031 Reset, then req0 alone with data0=0xA5 -> next cycle wEnable=1, wData=0xA5, ack0=1, count=1.
REQ-032 req0 and req1 held continuously, no reads -> grants alternate 0,1,0,1...; grants stop at count=8; almostFull rises when count reaches 6.
REQ-033 At count=8, rEnable_in and req1 both high -> no grant that cycle, count=7; next cycle ack1=1 and count=8.
REQ-034 At count=3, grant and read in the same cycle -> count stays 3 and wEnable=1.
REQ-035 fifoEmpty=1 with rEnable_in=1 -> rEnable=0, underflowErr=1 after the edge; errClear=1 -> underflowErr=0 after the next edge.
REQ-036 Assert n_rst=0 while count=5 and req1 is pending -> all outputs are 0 immediately; after release, a tie is won by req0.
